// File: rtl/map_sequencer.sv
// List map controller: pushes list[N-1..0] onto an internal stack, then pops each element,
// sends it through an external f unit and writes result[i] = f(list[i]).
module map_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [PTR_W-1:0]  start_len,
    output logic              list_rd_en,
    output logic [PTR_W-1:0]  list_rd_addr,
    input  logic [DATA_W-1:0] list_rd_data,
    output logic              f_req_valid,
    input  logic              f_req_ready,
    output logic [DATA_W-1:0] f_req_data,
    input  logic              f_rsp_valid,
    output logic              f_rsp_ready,
    input  logic [DATA_W-1:0] f_rsp_data,
    output logic              res_wr_en,
    output logic [PTR_W-1:0]  res_wr_addr,
    output logic [DATA_W-1:0] res_wr_data,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [PTR_W-1:0]  done_count,
    output logic              done_err,
    output logic              busy
);

    localparam logic [PTR_W-1:0] MaxLen = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] One    = PTR_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCallRd,
        StCallPush,
        StContPop,
        StContFreq,
        StContFrsp,
        StContWr,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   sp_q, sp_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  y_q, y_d;
    logic               err_q, err_d;
    logic               init_q;
    logic               push_en;
    logic [PTR_W-1:0]   pop_idx;
    logic [DATA_W-1:0]  stack_q [DEPTH];

    assign pop_idx = sp_q - One;

    // Holds start_ready low while reset is asserted even though state is already idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sp_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            err_q    <= err_d;
        end
    end

    // Stack storage needs no reset; sp_q defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[sp_q] <= list_rd_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        x_d      = x_q;
        y_d      = y_q;
        err_d    = err_q;
        push_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_valid && init_q) begin
                    if (start_len == '0) begin
                        state_d = StDone;
                    end else if (start_len > MaxLen) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        rd_ptr_d = start_len - One;
                        state_d  = StCallRd;
                    end
                end
            end
            StCallRd: begin
                state_d = StCallPush;
            end
            StCallPush: begin
                push_en = 1'b1;
                sp_d    = sp_q + One;
                if (rd_ptr_q == '0) begin
                    state_d = StContPop;
                end else begin
                    rd_ptr_d = rd_ptr_q - One;
                    state_d  = StCallRd;
                end
            end
            StContPop: begin
                x_d     = stack_q[pop_idx];
                sp_d    = pop_idx;
                state_d = StContFreq;
            end
            StContFreq: begin
                if (f_req_ready) begin
                    state_d = StContFrsp;
                end
            end
            StContFrsp: begin
                if (f_rsp_valid) begin
                    y_d     = f_rsp_data;
                    state_d = StContWr;
                end
            end
            StContWr: begin
                wr_ptr_d = wr_ptr_q + One;
                state_d  = (sp_q == '0) ? StDone : StContPop;
            end
            StDone: begin
                if (done_ready) begin
                    err_d    = 1'b0;
                    sp_d     = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from state so every one of them is zero while in reset.
    always_comb begin
        start_ready  = 1'b0;
        list_rd_en   = 1'b0;
        list_rd_addr = '0;
        f_req_valid  = 1'b0;
        f_req_data   = '0;
        f_rsp_ready  = 1'b0;
        res_wr_en    = 1'b0;
        res_wr_addr  = '0;
        res_wr_data  = '0;
        done_valid   = 1'b0;
        done_count   = '0;
        done_err     = 1'b0;
        busy         = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                start_ready = init_q;
            end
            StCallRd: begin
                list_rd_en   = 1'b1;
                list_rd_addr = rd_ptr_q;
            end
            StContFreq: begin
                f_req_valid = 1'b1;
                f_req_data  = x_q;
            end
            StContFrsp: begin
                f_rsp_ready = 1'b1;
            end
            StContWr: begin
                res_wr_en   = 1'b1;
                res_wr_addr = wr_ptr_q;
                res_wr_data = y_q;
            end
            StDone: begin
                done_valid = 1'b1;
                done_count = wr_ptr_q;
                done_err   = err_q;
            end
            default: begin
                busy = (state_q != StIdle);
            end
        endcase
    end

endmodule

// File: tb/tb_map_sequencer.sv
// Randomized bench for map_sequencer: list memory and f stub (y = x + 2) with programmable
// stalls; each job is checked against result[i] = list[i] + 2 and expected activity counts.
module tb_map_sequencer;

    localparam int DW    = 32;
    localparam int DEPTH = 6;
    localparam int PW    = 3;
    localparam int TMO   = 500;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [PW-1:0] start_len = '0;
    logic          list_rd_en;
    logic [PW-1:0] list_rd_addr;
    logic [DW-1:0] list_rd_data;
    logic          f_req_valid;
    logic          f_req_ready;
    logic [DW-1:0] f_req_data;
    logic          f_rsp_valid;
    logic          f_rsp_ready;
    logic [DW-1:0] f_rsp_data;
    logic          res_wr_en;
    logic [PW-1:0] res_wr_addr;
    logic [DW-1:0] res_wr_data;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [PW-1:0] done_count;
    logic          done_err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] list_mem [8];
    logic [DW-1:0] res_mem  [8];
    int            res_job  [8];
    int            job_id = 0;
    int            req_stall = 0;
    int            rsp_delay = 0;

    int            n_rd = 0, n_req = 0, n_wr = 0, n_unstable = 0;
    int            stall_cnt = 0, rsp_cnt = 0;
    logic          pend = 1'b0, stalled = 1'b0;
    logic [DW-1:0] pend_y = '0, last_req = '0;

    always #5 clk = ~clk;

    map_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_len    (start_len),
        .list_rd_en   (list_rd_en),
        .list_rd_addr (list_rd_addr),
        .list_rd_data (list_rd_data),
        .f_req_valid  (f_req_valid),
        .f_req_ready  (f_req_ready),
        .f_req_data   (f_req_data),
        .f_rsp_valid  (f_rsp_valid),
        .f_rsp_ready  (f_rsp_ready),
        .f_rsp_data   (f_rsp_data),
        .res_wr_en    (res_wr_en),
        .res_wr_addr  (res_wr_addr),
        .res_wr_data  (res_wr_data),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_count   (done_count),
        .done_err     (done_err),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // List memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (list_rd_en) list_rd_data <= list_mem[list_rd_addr];
    end

    // f unit stub with request stall and response delay.
    assign f_req_ready = f_req_valid && (stall_cnt >= req_stall);
    assign f_rsp_valid = pend && (rsp_cnt >= rsp_delay);
    assign f_rsp_data  = f_rsp_valid ? pend_y : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            stalled   <= 1'b0;
            stall_cnt <= 0;
            rsp_cnt   <= 0;
        end else begin
            if (f_req_valid && stalled && f_req_data != last_req) n_unstable <= n_unstable + 1;
            if (f_req_valid && !f_req_ready) begin
                stall_cnt <= stall_cnt + 1;
                stalled   <= 1'b1;
                last_req  <= f_req_data;
            end
            if (f_req_valid && f_req_ready) begin
                n_req     <= n_req + 1;
                stall_cnt <= 0;
                stalled   <= 1'b0;
                pend      <= 1'b1;
                pend_y    <= f_req_data + 32'd2;
                rsp_cnt   <= 0;
            end else if (pend && !f_rsp_valid) begin
                rsp_cnt <= rsp_cnt + 1;
            end
            if (f_rsp_valid && f_rsp_ready) pend <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && list_rd_en) n_rd <= n_rd + 1;
        if (rst_n && res_wr_en) begin
            res_mem[res_wr_addr] <= res_wr_data;
            res_job[res_wr_addr] <= job_id;
            n_wr <= n_wr + 1;
        end
    end

    function automatic logic any_out();
        return |{start_ready, list_rd_en, list_rd_addr, f_req_valid, f_req_data, f_rsp_ready,
                 res_wr_en, res_wr_addr, res_wr_data, done_valid, done_count, done_err, busy};
    endfunction

    // One job: n elements; fill=1 randomizes the list first; lat_chk checks 6N latency.
    task automatic run_job(input int n, input bit fill, input int stall, input int delay);
        int  rd0, req0, wr0, uns0, k, cnt_exp;
        bit  legal, seen;
        job_id++;
        req_stall = stall;
        rsp_delay = delay;
        if (fill) for (int i = 0; i < 8; i++) list_mem[i] = $urandom;
        legal   = (n >= 1) && (n <= DEPTH);
        cnt_exp = legal ? n : 0;
        k = 0;
        seen = 0;
        while (!start_ready && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check("start_ready_wait", 32'(start_ready), 32'd1);
        rd0 = n_rd; req0 = n_req; wr0 = n_wr; uns0 = n_unstable;
        start_valid = 1'b1;
        start_len   = PW'(n);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        k = 0;
        while (k < TMO) begin
            if (done_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (!seen) return;
        if (stall == 0 && delay == 0) check("latency", 32'(k), 32'(6 * cnt_exp));
        check("done_count", 32'(done_count), 32'(cnt_exp));
        check("done_err", 32'(done_err), (n > DEPTH) ? 32'd1 : 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        check("n_rd", 32'(n_rd - rd0), 32'(cnt_exp));
        check("n_req", 32'(n_req - req0), 32'(cnt_exp));
        check("n_wr", 32'(n_wr - wr0), 32'(cnt_exp));
        check("req_stable", 32'(n_unstable - uns0), 32'd0);
        for (int i = 0; i < cnt_exp; i++) begin
            check($sformatf("res_job[%0d]", i), 32'(res_job[i]), 32'(job_id));
            check($sformatf("res[%0d]", i), res_mem[i], list_mem[i] + 32'd2);
        end
        @(negedge clk);
        check("done_held", 32'(done_valid), 32'd1);
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        check("b2b_start_ready", 32'(start_ready), 32'd1);
        check("done_cleared", 32'(done_valid), 32'd0);
    endtask

    initial begin
        int k, wr0;
        for (int i = 0; i < 8; i++) begin
            list_mem[i] = '0;
            res_mem[i]  = '0;
            res_job[i]  = 0;
        end
        #1;
        check("rst_outputs", 32'(any_out()), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_outputs_clk", 32'(any_out()), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_low_before_edge", 32'(start_ready), 32'd0);
        @(negedge clk);
        check("ready_after_rst", 32'(start_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) list_mem[i] = DW'(i);
        run_job(6, 1'b0, 0, 0);
        list_mem[0] = 32'd9;
        run_job(1, 1'b0, 0, 0);
        run_job(0, 1'b1, 0, 0);
        run_job(7, 1'b1, 0, 0);
        run_job(6, 1'b1, 3, 4);

        for (int j = 0; j < 14; j++) begin
            if ($urandom_range(0, 1) == 0) run_job($urandom_range(0, 7), 1'b1, 0, 0);
            else run_job($urandom_range(0, 7), 1'b1, $urandom_range(0, 3), $urandom_range(0, 4));
        end

        // Reset in the middle of the CONT phase of a 6-element job.
        for (int i = 0; i < 8; i++) list_mem[i] = $urandom;
        req_stall = 0;
        rsp_delay = 0;
        start_valid = 1'b1;
        start_len   = PW'(6);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        k = 0;
        while (!res_wr_en && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check("midjob_reach_cont", 32'(res_wr_en), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midjob_rst_outputs", 32'(any_out()), 32'd0);
        wr0 = n_wr;
        repeat (3) @(negedge clk);
        check("midjob_rst_no_wr", 32'(n_wr - wr0), 32'd0);
        check("midjob_rst_outputs2", 32'(any_out()), 32'd0);
        rst_n = 1'b1;
        run_job(2, 1'b1, 1, 2);
        run_job(2, 1'b1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
